dma_stream_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one DMA stream sink between N_CH channel receivers.

---
 rtl/dma_stream_arbiter_pkg.sv | 18 +
 rtl/dma_stream_arbiter_if.sv | 39 +++
 rtl/dma_stream_arbiter_rr_pick.sv | 28 ++
 rtl/dma_stream_arbiter.sv | 140 ++++++++++++++
 tb/tb_dma_stream_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_stream_arbiter_pkg.sv
// rtl/dma_stream_arbiter_pkg.sv - arbiter state type, register map and channel-index width helper
package dsa_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam logic [7:0] ADDR_EN     = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_DROP   = 8'h02;
  localparam logic [7:0] ADDR_STATS  = 8'h10;

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_stream_arbiter_if.sv
// rtl/dma_stream_arbiter_if.sv - channel input streams, merged output stream and register port
interface dma_stream_arbiter_if #(
  parameter int N_CH = 4,
  parameter int DW   = 32
);
  import dsa_pkg::*;

  localparam int CHW = chw(N_CH);

  logic [N_CH-1:0]    i_sop;
  logic [N_CH-1:0]    i_eop;
  logic [N_CH*DW-1:0] i_data;
  logic [N_CH-1:0]    i_vld;
  logic [N_CH-1:0]    o_rdy;
  logic               o_sop;
  logic               o_eop;
  logic [DW-1:0]      o_data;
  logic               o_vld;
  logic               i_rdy;
  logic [CHW-1:0]     o_ch;
  logic [7:0]         i_mm_addr;
  logic               i_mm_wr;
  logic               i_mm_rd;
  logic [31:0]        i_mm_wr_data;
  logic [31:0]        o_mm_rd_data;

  modport slave (
    input  i_sop, i_eop, i_data, i_vld, i_rdy,
    input  i_mm_addr, i_mm_wr, i_mm_rd, i_mm_wr_data,
    output o_rdy, o_sop, o_eop, o_data, o_vld, o_ch, o_mm_rd_data
  );

  modport master (
    output i_sop, i_eop, i_data, i_vld, i_rdy,
    output i_mm_addr, i_mm_wr, i_mm_rd, i_mm_wr_data,
    input  o_rdy, o_sop, o_eop, o_data, o_vld, o_ch, o_mm_rd_data
  );

endinterface

// File: rtl/dma_stream_arbiter_rr_pick.sv
// rtl/dma_stream_arbiter_rr_pick.sv - round-robin priority encoder, search starts after last
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CHW  = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CHW-1:0]  last,
  output logic [CHW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [CHW-1:0] idx;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    // Walk farthest-first so the nearest requester after last overwrites the result.
    for (int i = N_CH; i >= 1; i--) begin
      idx = CHW'((int'(last) + i) % N_CH);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_stream_arbiter.sv
// rtl/dma_stream_arbiter.sv - packet round-robin arbiter merging N_CH streams onto one DMA sink
// Optional DSA_STATS_EN builds per-channel completed-packet counters at 0x10+k.
module dma_stream_arbiter
  import dsa_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  dma_stream_arbiter_if.slave bus
);

  localparam int               CHW     = chw(N_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CHW-1:0]   grant_q, last_q, pick_idx;
  logic             pick_any;
  logic [N_CH-1:0]  en_q, req, discard;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W:0]   drop_sum;
  logic             eop_xfer;
  logic [31:0]      rd_next;
  logic [DW-1:0]    ch_data [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_data[k] = bus.i_data[k*DW +: DW];
  end

  // Mid-packet non-sop beats arriving while idle are stale tails: swallow and count them.
  assign req      = (state_q == IDLE) ? (bus.i_vld &  bus.i_sop & en_q) : '0;
  assign discard  = (state_q == IDLE) ? (bus.i_vld & ~bus.i_sop & en_q) : '0;
  assign eop_xfer = (state_q == PKT) && bus.i_vld[grant_q] && bus.i_eop[grant_q] && bus.i_rdy;
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'($countones(discard));

  rr_pick #(.N_CH(N_CH), .CHW(CHW)) u_pick (
    .req     (req),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = PKT;
      PKT:     if (eop_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_vld  = 1'b0;
    bus.o_sop  = 1'b0;
    bus.o_eop  = 1'b0;
    bus.o_data = '0;
    bus.o_ch   = '0;
    bus.o_rdy  = '0;
    if (state_q == PKT) begin
      bus.o_vld          = bus.i_vld[grant_q];
      bus.o_sop          = bus.i_sop[grant_q];
      bus.o_eop          = bus.i_eop[grant_q];
      bus.o_data         = ch_data[grant_q];
      bus.o_ch           = grant_q;
      bus.o_rdy[grant_q] = bus.i_rdy;
    end else begin
      bus.o_rdy = discard;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      last_q  <= CHW'(N_CH - 1);
    end else begin
      if (state_q == IDLE && pick_any) grant_q <= pick_idx;
      if (eop_xfer)                    last_q  <= grant_q;
    end
  end

`ifdef DSA_STATS_EN
  logic [CNT_W-1:0] pkt_cnt [N_CH];
  logic             stat_hit;
  logic [CHW-1:0]   stat_idx;

  assign stat_hit = (int'(bus.i_mm_addr) >= int'(ADDR_STATS)) &&
                    (int'(bus.i_mm_addr) <  int'(ADDR_STATS) + N_CH);
  assign stat_idx = CHW'(bus.i_mm_addr - ADDR_STATS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) pkt_cnt[k] <= '0;
    end else if (bus.i_mm_wr && stat_hit) begin
      for (int k = 0; k < N_CH; k++) pkt_cnt[k] <= '0;
    end else if (eop_xfer && pkt_cnt[grant_q] != CNT_MAX) begin
      pkt_cnt[grant_q] <= pkt_cnt[grant_q] + 1'b1;
    end
  end
`endif

  always_comb begin
    rd_next = '0;
    if (bus.i_mm_addr == ADDR_EN) begin
      rd_next[N_CH-1:0] = en_q;
    end else if (bus.i_mm_addr == ADDR_STATUS) begin
      rd_next[0]        = (state_q == PKT);
      rd_next[8 +: CHW] = grant_q;
      rd_next[16 +: CHW] = last_q;
    end else if (bus.i_mm_addr == ADDR_DROP) begin
      rd_next[CNT_W-1:0] = drop_cnt;
    end
`ifdef DSA_STATS_EN
    else if (stat_hit) begin
      rd_next[CNT_W-1:0] = pkt_cnt[stat_idx];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q             <= '1;
      drop_cnt         <= '0;
      bus.o_mm_rd_data <= '0;
    end else begin
      if (bus.i_mm_wr && bus.i_mm_addr == ADDR_EN) en_q <= bus.i_mm_wr_data[N_CH-1:0];
      if (bus.i_mm_wr && bus.i_mm_addr == ADDR_DROP) drop_cnt <= '0;
      else if (drop_sum[CNT_W])                      drop_cnt <= CNT_MAX;
      else                                           drop_cnt <= drop_sum[CNT_W-1:0];
      if (bus.i_mm_rd) bus.o_mm_rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_dma_stream_arbiter.sv
// tb/tb_dma_stream_arbiter.sv - self-checking bench for dma_stream_arbiter, optional DSA_STATS_EN
module tb_dma_stream_arbiter;

  localparam int N_CH  = 4;
  localparam int DW    = 32;
  localparam int CNT_W = 16;

  typedef struct {
    logic [DW-1:0] data;
    bit            sop;
    bit            eop;
    int            ch;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_stream_arbiter_if #(.N_CH(N_CH), .DW(DW)) bus ();

  dma_stream_arbiter #(.N_CH(N_CH), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t           src_q [N_CH][$];
  beat_t           exp_q [$];
  int              exp_rd;
  int              obs_order [$];
  int              checks   = 0;
  int              failures = 0;
  bit              toggle_rdy = 1'b0;
  int              cyc = 0;
  logic [N_CH-1:0] acc;
  logic [N_CH-1:0] watch_off = '0;
  bit              lit_req = 1'b0;
  string           lit_name;
  logic [31:0]     lit_act, lit_exp;

  int              m_last;
  logic [N_CH-1:0] m_en;
  int              m_drop;
  int              m_pkts [N_CH];

  bit after_eop  = 1'b0;
  bit first_beat = 1'b1;

  always @(negedge clk) begin
    beat_t e;
    if (lit_req) begin
      checks++;
      if (lit_act !== lit_exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", lit_name, lit_act, lit_exp);
      end
    end
    if (rst) begin
      exp_rd     = 0;
      after_eop  = 1'b0;
      first_beat = 1'b1;
      obs_order.delete();
    end else begin
      if (watch_off != '0) begin
        checks++;
        if ((bus.o_rdy & watch_off) !== '0) begin
          failures++;
          $display("FAIL disabled_rdy: got o_rdy=%b expected zero under mask %b", bus.o_rdy, watch_off);
        end
      end
      if (after_eop) begin
        checks++;
        if (bus.o_vld !== 1'b0) begin
          failures++;
          $display("FAIL idle_gap: got o_vld=%b expected 0", bus.o_vld);
        end
      end
      if (bus.o_vld) begin
        checks++;
        if ((bus.o_rdy & ~(N_CH'(1) << bus.o_ch)) !== '0 || bus.o_rdy[bus.o_ch] !== bus.i_rdy) begin
          failures++;
          $display("FAIL rdy_route: got o_rdy=%b expected only bit %0d = %b", bus.o_rdy, bus.o_ch, bus.i_rdy);
        end
      end
      if (bus.o_vld && bus.i_rdy) begin
        checks++;
        if (exp_rd >= exp_q.size()) begin
          failures++;
          $display("FAIL unexpected_beat: got data=%h ch=%0d expected no beat", bus.o_data, bus.o_ch);
        end else begin
          e = exp_q[exp_rd];
          exp_rd++;
          if (bus.o_data !== e.data || bus.o_sop !== e.sop || bus.o_eop !== e.eop ||
              int'(bus.o_ch) != e.ch) begin
            failures++;
            $display("FAIL beat: got data=%h sop=%b eop=%b ch=%0d expected data=%h sop=%b eop=%b ch=%0d",
                     bus.o_data, bus.o_sop, bus.o_eop, bus.o_ch, e.data, e.sop, e.eop, e.ch);
          end
        end
        if (first_beat) obs_order.push_back(int'(bus.o_ch));
        first_beat = bus.o_eop;
        after_eop  = bus.o_eop;
      end else begin
        after_eop = 1'b0;
      end
    end
  end

  task automatic drive();
    for (int k = 0; k < N_CH; k++) begin
      if (src_q[k].size() > 0) begin
        bus.i_vld[k]             = 1'b1;
        bus.i_sop[k]             = src_q[k][0].sop;
        bus.i_eop[k]             = src_q[k][0].eop;
        bus.i_data[k*DW +: DW]   = src_q[k][0].data;
      end else begin
        bus.i_vld[k]             = 1'b0;
        bus.i_sop[k]             = 1'b0;
        bus.i_eop[k]             = 1'b0;
        bus.i_data[k*DW +: DW]   = '0;
      end
    end
    bus.i_rdy = toggle_rdy ? cyc[0] : 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk);
    acc = bus.i_vld & bus.o_rdy;
    @(posedge clk);
    #1;
    for (int k = 0; k < N_CH; k++)
      if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    cyc++;
    drive();
  endtask

  task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_name = name;
    lit_act  = act;
    lit_exp  = exp;
    lit_req  = 1'b1;
    cycle();
    lit_req  = 1'b0;
  endtask

  task automatic mm_write(input logic [7:0] a, input logic [31:0] d);
    bus.i_mm_addr    = a;
    bus.i_mm_wr_data = d;
    bus.i_mm_wr      = 1'b1;
    cycle();
    bus.i_mm_wr      = 1'b0;
  endtask

  task automatic mm_read(input logic [7:0] a, output logic [31:0] d);
    bus.i_mm_addr = a;
    bus.i_mm_rd   = 1'b1;
    cycle();
    bus.i_mm_rd   = 1'b0;
    d = bus.o_mm_rd_data;
  endtask

  task automatic add_pkt(input int ch, input int len, input int tag, input int extra_sop);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {ch[7:0], tag[7:0], i[15:0]};
      b.sop  = (i == 0) || (i == extra_sop);
      b.eop  = (i == len - 1);
      b.ch   = ch;
      src_q[ch].push_back(b);
    end
    drive();
  endtask

  task automatic add_junk(input int ch, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {8'hee, ch[7:0], i[15:0]};
      b.sop  = 1'b0;
      b.eop  = 1'b0;
      b.ch   = ch;
      src_q[ch].push_back(b);
    end
    drive();
  endtask

  // Queue-level view: every enabled channel with a pending packet competes; whole packets in turn.
  task automatic model_run();
    beat_t mq [N_CH][$];
    beat_t b;
    int    c;
    bit    found;
    for (int k = 0; k < N_CH; k++) begin
      mq[k] = src_q[k];
      while (mq[k].size() > 0 && !mq[k][0].sop && m_en[k]) begin
        void'(mq[k].pop_front());
        m_drop++;
      end
    end
    while (1) begin
      found = 1'b0;
      c     = 0;
      for (int i = 1; i <= N_CH && !found; i++) begin
        c = (m_last + i) % N_CH;
        if (m_en[c] && mq[c].size() > 0) found = 1'b1;
      end
      if (!found) break;
      do begin
        b    = mq[c].pop_front();
        b.ch = c;
        exp_q.push_back(b);
      end while (!b.eop && mq[c].size() > 0);
      if (b.eop) m_pkts[c]++;
      m_last = c;
    end
  endtask

  task automatic run_drain(input int max_cyc, input logic [N_CH-1:0] ignore);
    int n;
    bit busy;
    n = 0;
    do begin
      cycle();
      n++;
      busy = (exp_rd < exp_q.size());
      for (int k = 0; k < N_CH; k++)
        if (!ignore[k] && src_q[k].size() > 0) busy = 1'b1;
    end while (busy && n < max_cyc);
    expect_lit("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N_CH; k++) src_q[k].delete();
    exp_q.delete();
    drive();
    cycle();
    cycle();
    rst    = 1'b0;
    m_last = N_CH - 1;
    m_en   = '1;
    m_drop = 0;
    for (int k = 0; k < N_CH; k++) m_pkts[k] = 0;
    cycle();
  endtask

  function automatic logic [31:0] order_code();
    logic [31:0] c;
    c = '0;
    foreach (obs_order[i]) c = (c << 4) | 32'(obs_order[i] + 1);
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          n;
    bus.i_mm_addr    = '0;
    bus.i_mm_wr      = 1'b0;
    bus.i_mm_rd      = 1'b0;
    bus.i_mm_wr_data = '0;
    drive();
    do_reset();

    expect_lit("rst_o_vld", {31'd0, bus.o_vld}, 32'd0);
    expect_lit("rst_o_rdy", 32'(bus.o_rdy), 32'd0);
    expect_lit("rst_rd_data", bus.o_mm_rd_data, 32'd0);
    mm_read(8'h00, rd);
    expect_lit("rst_en", rd, 32'h0000_000f);
    mm_read(8'h55, rd);
    expect_lit("unmapped", rd, 32'd0);
    mm_read(8'h01, rd);
    expect_lit("rst_status", rd, 32'h0003_0000);
    expect_lit("rd_hold", bus.o_mm_rd_data, 32'h0003_0000);
    mm_read(8'h02, rd);
    expect_lit("rst_drop", rd, 32'd0);

    // ch0 and ch2 request together: ch0 first, then ch2
    add_pkt(0, 4, 1, -1);
    add_pkt(2, 4, 1, -1);
    model_run();
    run_drain(200, '0);
    expect_lit("t1_order", order_code(), 32'h13);

    // all channels streaming, two packets each of varied lengths
    do_reset();
    for (int k = 0; k < N_CH; k++) begin
      add_pkt(k, k + 1, 2, -1);
      add_pkt(k, 4 - k, 3, -1);
    end
    model_run();
    run_drain(300, '0);
    expect_lit("t2_order", order_code(), 32'h1234_1234);

    // 8-beat ch1 packet with a stray sop at beat 4, sink ready toggling
    do_reset();
    add_pkt(1, 8, 4, 4);
    model_run();
    toggle_rdy = 1'b1;
    run_drain(300, '0);
    toggle_rdy = 1'b0;
    expect_lit("t3_beats", exp_rd, 32'd8);
    expect_lit("t3_order", order_code(), 32'h2);

    // non-sop beats in idle are discarded and counted
    do_reset();
    add_junk(3, 3);
    model_run();
    run_drain(100, '0);
    mm_read(8'h02, rd);
    expect_lit("t4_drop", rd, 32'd3);
    mm_write(8'h02, 32'hffff_ffff);
    mm_read(8'h02, rd);
    expect_lit("t4_drop_clr", rd, 32'd0);

    // ch1 masked off; ch2 disabled while its packet is in flight
    do_reset();
    mm_write(8'h00, 32'h0000_000d);
    m_en      = 4'b1101;
    watch_off = 4'b0010;
    add_pkt(1, 3, 5, -1);
    add_pkt(0, 3, 5, -1);
    add_pkt(2, 6, 5, -1);
    model_run();
    n = 0;
    while (obs_order.size() < 2 && n < 100) begin
      cycle();
      n++;
    end
    mm_write(8'h00, 32'h0000_0009);
    m_en = 4'b1001;
    run_drain(200, 4'b0010);
    watch_off = '0;
    expect_lit("t5_order", order_code(), 32'h13);
    expect_lit("t5_ch1_pending", src_q[1].size(), 32'd3);
    mm_read(8'h00, rd);
    expect_lit("t5_en", rd, 32'h0000_0009);

    // completed-packet counter, then reset in the middle of a packet
    do_reset();
    for (int i = 0; i < 5; i++) add_pkt(2, 2, 6 + i, -1);
    model_run();
    run_drain(200, '0);
    mm_read(8'h12, rd);
`ifdef DSA_STATS_EN
    expect_lit("t6_stats", rd, 32'd5);
`else
    expect_lit("t6_stats", rd, 32'd0);
`endif
    add_pkt(0, 6, 20, -1);
    model_run();
    n = 0;
    while (exp_rd < exp_q.size() - 4 && n < 100) begin
      cycle();
      n++;
    end
    expect_lit("t6_midpkt", {31'd0, bus.o_vld}, 32'd1);
    rst = 1'b1;
    #1;
    expect_lit("rstmid_o_vld", {31'd0, bus.o_vld}, 32'd0);
    expect_lit("rstmid_o_ch", 32'(bus.o_ch), 32'd0);
    do_reset();
    mm_read(8'h01, rd);
    expect_lit("rstmid_status", rd, 32'h0003_0000);
    mm_read(8'h12, rd);
    expect_lit("rstmid_stats", rd, 32'd0);
    mm_read(8'h02, rd);
    expect_lit("rstmid_drop", rd, 32'd0);

    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
